rf_pkt_tx_framer: RTL

- Transmit-side counterpart of the RF receive path (shift buffer, packet register, SPI byte extraction).
- Collects PAYLOAD_BYTES bytes from the TX-side byte source (SPI slave output) over a valid/ready handshake.
- Frames the payload as preamble + sync word + payload and shifts it out MSB-first on tx_out, one bit per bit_en strobe.
- The framing matches what the receive shift buffer detects, so a loopback of tx_out into rfin raises pkt_rec.

---
 rtl/rf_pkt_pkg.sv | 33 +++
 rtl/rf_crc8_byte.sv | 14 +
 rtl/rf_pkt_tx_framer.sv | 100 ++++++++++
 3 files changed

// File: rtl/rf_pkt_pkg.sv
// rf_pkt_pkg: shared RF packet framing constants and TX state encoding; RF_TX_CRC8_EN adds the CRC trailer
package rf_pkt_pkg;
    localparam int DEF_PAYLOAD_BYTES = 6;
    localparam int DEF_PREAMBLE_LEN = 16;
    localparam logic [7:0] DEF_SYNC_WORD = 8'hA7;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int SYNC_BITS = 8;
`ifdef RF_TX_CRC8_EN
    localparam int CRC_BITS = 8;
`else
    localparam int CRC_BITS = 0;
`endif
    localparam int DEF_FRAME_BITS = DEF_PREAMBLE_LEN + SYNC_BITS + 8 * DEF_PAYLOAD_BYTES + CRC_BITS;
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PREAMBLE,
        SYNC,
        PAYLOAD,
`ifdef RF_TX_CRC8_EN
        CRC,
`endif
        DONE
    } tx_state_t;
`ifdef RF_TX_CRC8_EN
    localparam tx_state_t POST_PAYLOAD = CRC;
`else
    localparam tx_state_t POST_PAYLOAD = DONE;
`endif
    function automatic int frame_bits(input int preamble_len, input int payload_bytes);
        return preamble_len + SYNC_BITS + 8 * payload_bytes + CRC_BITS;
    endfunction
endpackage

// File: rtl/rf_crc8_byte.sv
// rf_crc8_byte: combinational CRC-8 (CRC8_POLY, MSB-first, no reflection) update over one byte
module rf_crc8_byte
    import rf_pkt_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);
    always_comb begin
        crc_out = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[7] ? {crc_out[6:0], 1'b0} ^ CRC8_POLY : {crc_out[6:0], 1'b0};
    end
endmodule

// File: rtl/rf_pkt_tx_framer.sv
// rf_pkt_tx_framer: buffers a payload, then shifts preamble + sync + payload MSB-first, one bit per bit_en
// RF_TX_CRC8_EN appends a CRC-8 of the payload after the last payload byte
module rf_pkt_tx_framer
    import rf_pkt_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
    parameter int         PREAMBLE_LEN  = DEF_PREAMBLE_LEN,
    parameter logic [7:0] SYNC_WORD     = DEF_SYNC_WORD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       frame_done
);
    localparam int IW = PAYLOAD_BYTES > 1 ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [3:0] LAST_BYTE = 4'(PAYLOAD_BYTES - 1);
    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_LEN - 1);
    tx_state_t state, state_nx;
    logic [4:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic [7:0] mem [PAYLOAD_BYTES];
    logic [7:0] cur_byte;
    logic accept, sending, field_last, tx_bit;
    assign accept = din_valid && din_ready;
    assign sending = bit_en && state != IDLE && state != FILL && state != DONE;
    assign field_last = state == PREAMBLE ? bit_cnt == PRE_LAST : bit_cnt == 5'd7;
    // ~bit_cnt[2:0] == 7 - bit_cnt selects bits MSB-first
    assign tx_bit = state == PREAMBLE ? ~bit_cnt[0] : cur_byte[~bit_cnt[2:0]];
`ifdef RF_TX_CRC8_EN
    logic [7:0] crc_q, crc_nx;
    rf_crc8_byte u_crc (
        .crc_in (crc_q),
        .byte_in(din),
        .crc_out(crc_nx)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else if (accept) crc_q <= crc_nx;
        else if (frame_done) crc_q <= '0;
    end
    assign cur_byte = state == SYNC ? SYNC_WORD : state == CRC ? crc_q : mem[byte_cnt[IW-1:0]];
`else
    assign cur_byte = state == SYNC ? SYNC_WORD : mem[byte_cnt[IW-1:0]];
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = FILL;
            FILL:     state_nx = accept && byte_cnt == LAST_BYTE ? PREAMBLE : FILL;
            PREAMBLE: state_nx = bit_en && field_last ? SYNC : PREAMBLE;
            SYNC:     state_nx = bit_en && field_last ? PAYLOAD : SYNC;
            PAYLOAD:  state_nx = bit_en && field_last && byte_cnt == LAST_BYTE ? POST_PAYLOAD : PAYLOAD;
`ifdef RF_TX_CRC8_EN
            CRC:      state_nx = bit_en && field_last ? DONE : CRC;
`endif
            DONE:     state_nx = bit_en ? FILL : DONE;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        din_ready = state == FILL && byte_cnt <= LAST_BYTE;
        frame_done = state == DONE && bit_en;
    end
    // byte_cnt doubles as the payload read index once the sync word has gone out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            byte_cnt <= '0;
            tx_out <= 1'b0;
            tx_busy <= 1'b0;
            for (int i = 0; i < PAYLOAD_BYTES; i++) mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[byte_cnt[IW-1:0]] <= din;
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (sending) begin
                tx_out <= tx_bit;
                tx_busy <= 1'b1;
                bit_cnt <= field_last ? 5'd0 : bit_cnt + 5'd1;
                if (field_last && state == SYNC) byte_cnt <= '0;
                if (field_last && state == PAYLOAD && byte_cnt != LAST_BYTE) byte_cnt <= byte_cnt + 4'd1;
            end
            if (frame_done) begin
                tx_out <= 1'b0;
                tx_busy <= 1'b0;
                byte_cnt <= '0;
            end
        end
    end
endmodule
